// File: rtl/wb_uart_lite.sv
`default_nettype none
// ============================================================================
// wb_uart_lite : Wishbone B4 pipelined 8N1 UART with RX/TX byte FIFOs.
// Optional hardware flow control (CTS/RTS) enabled by WBUART_HWFLOW_EN.
// Revision: 1.0
// ============================================================================

module wb_uart_lite_fifo #(
    parameter int LGFLEN = 4
) (
    input  logic              clk_i,
    input  logic              reset_ni,
    input  logic              push_i,
    input  logic [7:0]        data_i,
    input  logic              pop_i,
    output logic [7:0]        data_o,
    output logic              empty_o,
    output logic              full_o,
    output logic [LGFLEN:0]   count_o
);
    localparam int DEPTH = 1 << LGFLEN;

    logic [7:0]        mem_q [DEPTH];
    logic [LGFLEN-1:0] wr_q, rd_q;
    logic [LGFLEN:0]   cnt_q;
    logic              push_ok, pop_ok;

    // A pop frees a slot in the same cycle, so push-on-full succeeds with it.
    assign pop_ok  = pop_i && !empty_o;
    assign push_ok = push_i && (!full_o || pop_ok);

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_ok) wr_q <= wr_q + 1'b1;
            if (pop_ok)  rd_q <= rd_q + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_q] <= data_i;
    end

    assign data_o  = mem_q[rd_q];
    assign empty_o = (cnt_q == '0);
    assign full_o  = cnt_q[LGFLEN];
    assign count_o = cnt_q;
endmodule

module wb_uart_lite #(
    parameter logic [23:0] INITIAL_SETUP = 24'd1736,
    parameter int          LGFLEN        = 4
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_wb_cyc,
    input  logic        i_wb_stb,
    input  logic        i_wb_we,
    input  logic [1:0]  i_wb_addr,
    input  logic [31:0] i_wb_data,
    input  logic [3:0]  i_wb_sel,
    output logic        o_wb_stall,
    output logic        o_wb_ack,
    output logic [31:0] o_wb_data,
    input  logic        i_uart_rx,
    output logic        o_uart_tx,
    input  logic        i_cts_n,
    output logic        o_rts_n,
    output logic        o_uart_rx_int,
    output logic        o_uart_tx_int,
    output logic        o_uart_rxfifo_int,
    output logic        o_uart_txfifo_int
);
    localparam int         DEPTH = 1 << LGFLEN;
    localparam logic [8:0] DEPTH9 = 9'(DEPTH);
    localparam logic [8:0] HALF9  = 9'(DEPTH / 2);

    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK
    } rx_state_t;
    typedef enum logic {
        TX_IDLE, TX_BUSY
    } tx_state_t;

    logic        bus_wr, bus_rd;
    logic [23:0] setup_q, setup_d, setup_merge;
    logic [1:0]  rx_sync_q, cts_sync_q;
    logic        rx_s, cts_s;
    logic [31:0] rdata;
    logic        ack_q;
    logic [31:0] wb_data_q;

    logic        rx_push_q, rx_ferr_q, rx_prev_q;
    rx_state_t   rx_state_q;
    logic [23:0] rx_cnt_q, rx_div_q;
    logic [2:0]  rx_bit_q;
    logic [7:0]  rx_sr_q;
    logic        ferr_sticky_q, overrun_q;

    tx_state_t   tx_state_q;
    logic        tx_q;
    logic [8:0]  tx_sr_q;
    logic [3:0]  tx_nbit_q;
    logic [23:0] tx_cnt_q, tx_div_q;
    logic        tx_flow_ok, tx_start, tx_busy;

    logic              rx_pop, rx_empty, rx_full;
    logic [7:0]        rx_data;
    logic [LGFLEN:0]   rx_count;
    logic              tx_push, tx_empty, tx_full;
    logic [7:0]        tx_data;
    logic [LGFLEN:0]   tx_count;
    logic [8:0]        rx_fill, tx_free;
    logic              rx_int_q, tx_int_q, rxfifo_int_q, txfifo_int_q;
    logic              w_unused;

    assign bus_wr = i_wb_cyc && i_wb_stb && i_wb_we;
    assign bus_rd = i_wb_cyc && i_wb_stb && !i_wb_we;
    assign rx_s   = rx_sync_q[1];
    assign cts_s  = cts_sync_q[1];
    assign w_unused = ^{i_wb_sel[3], i_wb_data[31:24]};

    always_comb begin
        setup_merge = setup_q;
        for (int k = 0; k < 3; k++) begin
            if (i_wb_sel[k]) setup_merge[8*k +: 8] = i_wb_data[8*k +: 8];
        end
        setup_d = setup_q;
        if (bus_wr && i_wb_addr == 2'd0)
            setup_d = (setup_merge < 24'd16) ? 24'd16 : setup_merge;
    end

    assign rx_pop  = bus_rd && (i_wb_addr == 2'd2);
    assign tx_push = bus_wr && (i_wb_addr == 2'd3) && i_wb_sel[0];

    wb_uart_lite_fifo #(.LGFLEN(LGFLEN)) u_rx_fifo (
        .clk_i(i_clk), .reset_ni(i_reset_n),
        .push_i(rx_push_q), .data_i(rx_sr_q), .pop_i(rx_pop),
        .data_o(rx_data), .empty_o(rx_empty), .full_o(rx_full), .count_o(rx_count)
    );

    wb_uart_lite_fifo #(.LGFLEN(LGFLEN)) u_tx_fifo (
        .clk_i(i_clk), .reset_ni(i_reset_n),
        .push_i(tx_push), .data_i(i_wb_data[7:0]), .pop_i(tx_start),
        .data_o(tx_data), .empty_o(tx_empty), .full_o(tx_full), .count_o(tx_count)
    );

    assign rx_fill = 9'(rx_count);
    assign tx_free = DEPTH9 - 9'(tx_count);
    assign tx_busy = !tx_empty || (tx_state_q == TX_BUSY);

`ifdef WBUART_HWFLOW_EN
    logic rts_q;
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) rts_q <= 1'b0;
        else            rts_q <= (rx_fill >= DEPTH9 - 9'd1);
    end
    assign o_rts_n    = rts_q;
    assign tx_flow_ok = !cts_s;
`else
    assign o_rts_n    = 1'b0;
    assign tx_flow_ok = 1'b1;
`endif

    always_comb begin
        rdata = 32'h0;
        case (i_wb_addr)
            2'd0: rdata = {8'h0, setup_q};
            2'd1: rdata = {4'(LGFLEN), 3'b0, tx_free, 7'b0, rx_fill};
            2'd2: rdata = {21'b0, overrun_q, ferr_sticky_q, rx_empty,
                           rx_empty ? 8'h0 : rx_data};
            default: rdata = {20'b0, cts_s, rx_s, tx_busy, tx_full, 8'h0};
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            ack_q         <= 1'b0;
            wb_data_q     <= 32'h0;
            setup_q       <= INITIAL_SETUP;
            rx_sync_q     <= 2'b11;
            cts_sync_q    <= 2'b11;
            ferr_sticky_q <= 1'b0;
            overrun_q     <= 1'b0;
            rx_int_q      <= 1'b0;
            tx_int_q      <= 1'b1;
            rxfifo_int_q  <= 1'b0;
            txfifo_int_q  <= 1'b1;
        end else begin
            ack_q      <= i_wb_cyc && i_wb_stb;
            if (bus_rd) wb_data_q <= rdata;
            setup_q    <= setup_d;
            rx_sync_q  <= {rx_sync_q[0], i_uart_rx};
            cts_sync_q <= {cts_sync_q[0], i_cts_n};
            if (bus_wr && i_wb_addr == 2'd2) begin
                ferr_sticky_q <= 1'b0;
                overrun_q     <= 1'b0;
            end
            if (rx_ferr_q) ferr_sticky_q <= 1'b1;
            if (rx_push_q && rx_full && !rx_pop) overrun_q <= 1'b1;
            rx_int_q     <= !rx_empty;
            tx_int_q     <= !tx_full;
            rxfifo_int_q <= (rx_fill >= HALF9);
            txfifo_int_q <= (tx_free >= HALF9);
        end
    end

    // Receiver: start edge, mid-baud confirmation, then one sample per baud.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            rx_state_q <= RX_IDLE;
            rx_prev_q  <= 1'b1;
            rx_cnt_q   <= '0;
            rx_div_q   <= INITIAL_SETUP;
            rx_bit_q   <= '0;
            rx_sr_q    <= '0;
            rx_push_q  <= 1'b0;
            rx_ferr_q  <= 1'b0;
        end else begin
            rx_prev_q <= rx_s;
            rx_push_q <= 1'b0;
            rx_ferr_q <= 1'b0;
            case (rx_state_q)
                RX_IDLE: begin
                    if (rx_prev_q && !rx_s) begin
                        rx_div_q   <= setup_q;
                        rx_cnt_q   <= {1'b0, setup_q[23:1]} - 24'd1;
                        rx_state_q <= RX_START;
                    end
                end
                RX_START: begin
                    if (rx_cnt_q != '0) rx_cnt_q <= rx_cnt_q - 24'd1;
                    else if (!rx_s) begin
                        rx_cnt_q   <= rx_div_q - 24'd1;
                        rx_bit_q   <= '0;
                        rx_state_q <= RX_DATA;
                    end else rx_state_q <= RX_IDLE;
                end
                RX_DATA: begin
                    if (rx_cnt_q != '0) rx_cnt_q <= rx_cnt_q - 24'd1;
                    else begin
                        rx_sr_q  <= {rx_s, rx_sr_q[7:1]};
                        rx_cnt_q <= rx_div_q - 24'd1;
                        rx_bit_q <= rx_bit_q + 3'd1;
                        if (rx_bit_q == 3'd7) rx_state_q <= RX_STOP;
                    end
                end
                RX_STOP: begin
                    if (rx_cnt_q != '0) rx_cnt_q <= rx_cnt_q - 24'd1;
                    else begin
                        rx_push_q  <= 1'b1;
                        rx_ferr_q  <= !rx_s;
                        rx_state_q <= rx_s ? RX_IDLE : RX_BREAK;
                    end
                end
                default: begin
                    // A low stop bit: wait for the line to idle before re-arming.
                    if (rx_s) rx_state_q <= RX_IDLE;
                end
            endcase
        end
    end

    // A new character may start on the last stop-bit cycle for gapless frames.
    assign tx_start = !tx_empty && tx_flow_ok &&
                      ((tx_state_q == TX_IDLE) ||
                       (tx_cnt_q == '0 && tx_nbit_q == 4'd0));

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            tx_state_q <= TX_IDLE;
            tx_q       <= 1'b1;
            tx_sr_q    <= '1;
            tx_nbit_q  <= '0;
            tx_cnt_q   <= '0;
            tx_div_q   <= INITIAL_SETUP;
        end else if (tx_start) begin
            tx_state_q <= TX_BUSY;
            tx_q       <= 1'b0;
            tx_sr_q    <= {1'b1, tx_data};
            tx_nbit_q  <= 4'd9;
            tx_div_q   <= setup_q;
            tx_cnt_q   <= setup_q - 24'd1;
        end else if (tx_state_q == TX_BUSY) begin
            if (tx_cnt_q != '0) tx_cnt_q <= tx_cnt_q - 24'd1;
            else if (tx_nbit_q == 4'd0) begin
                tx_state_q <= TX_IDLE;
                tx_q       <= 1'b1;
            end else begin
                tx_q      <= tx_sr_q[0];
                tx_sr_q   <= {1'b1, tx_sr_q[8:1]};
                tx_nbit_q <= tx_nbit_q - 4'd1;
                tx_cnt_q  <= tx_div_q - 24'd1;
            end
        end
    end

    assign o_wb_stall        = 1'b0;
    assign o_wb_ack          = ack_q;
    assign o_wb_data         = wb_data_q;
    assign o_uart_tx         = tx_q;
    assign o_uart_rx_int     = rx_int_q;
    assign o_uart_tx_int     = tx_int_q;
    assign o_uart_rxfifo_int = rxfifo_int_q;
    assign o_uart_txfifo_int = txfifo_int_q;
endmodule

`default_nettype wire

// File: tb/tb_wb_uart_lite.sv
`default_nettype none
// ============================================================================
// tb_wb_uart_lite : directed self-checking bench for wb_uart_lite.
// Revision: 1.0
// ============================================================================
module tb_wb_uart_lite;
    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [1:0]  cyc;
    logic        stb, we;
    logic [1:0]  addr;
    logic [31:0] wdat;
    logic [3:0]  sel;
    logic        lb, rxd0, rxd1, cts_n;
    logic        rx0;
    logic        stall0, ack0, tx0, rts0, rxi0, txi0, rxfi0, txfi0;
    logic        stall1, ack1, tx1, rts1, rxi1, txi1, rxfi1, txfi1;
    logic [31:0] rdat0, rdat1;

    int checks = 0;
    int failures = 0;
    int cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    assign rx0 = lb ? tx0 : rxd0;

    wb_uart_lite u_dut0 (
        .i_clk(clk), .i_reset_n(rst_n),
        .i_wb_cyc(cyc[0]), .i_wb_stb(stb), .i_wb_we(we), .i_wb_addr(addr),
        .i_wb_data(wdat), .i_wb_sel(sel),
        .o_wb_stall(stall0), .o_wb_ack(ack0), .o_wb_data(rdat0),
        .i_uart_rx(rx0), .o_uart_tx(tx0), .i_cts_n(cts_n), .o_rts_n(rts0),
        .o_uart_rx_int(rxi0), .o_uart_tx_int(txi0),
        .o_uart_rxfifo_int(rxfi0), .o_uart_txfifo_int(txfi0)
    );

    wb_uart_lite #(.LGFLEN(2)) u_dut1 (
        .i_clk(clk), .i_reset_n(rst_n),
        .i_wb_cyc(cyc[1]), .i_wb_stb(stb), .i_wb_we(we), .i_wb_addr(addr),
        .i_wb_data(wdat), .i_wb_sel(sel),
        .o_wb_stall(stall1), .o_wb_ack(ack1), .o_wb_data(rdat1),
        .i_uart_rx(rxd1), .o_uart_tx(tx1), .i_cts_n(cts_n), .o_rts_n(rts1),
        .o_uart_rx_int(rxi1), .o_uart_tx_int(txi1),
        .o_uart_rxfifo_int(rxfi1), .o_uart_txfifo_int(txfi1)
    );

    typedef struct {
        int          dut;
        logic        we;
        logic [1:0]  addr;
        logic [31:0] wd;
        logic [3:0]  sel;
        logic [31:0] exp;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_to(input int t);
        while (cyc_cnt < t) tick();
    endtask

    task automatic bus(input int d, input logic w, input logic [1:0] a,
                       input logic [31:0] wd, input logic [3:0] s, output logic [31:0] rd);
        cyc  = (d == 0) ? 2'b01 : 2'b10;
        stb  = 1'b1;
        we   = w;
        addr = a;
        wdat = wd;
        sel  = s;
        tick();
        cyc = 2'b00;
        stb = 1'b0;
        we  = 1'b0;
        rd  = (d == 0) ? rdat0 : rdat1;
        check("ack", {31'b0, (d == 0) ? ack0 : ack1}, 32'h1);
    endtask

    task automatic rd_chk(input int d, input logic [1:0] a, input string name, input logic [31:0] exp);
        logic [31:0] v;
        bus(d, 1'b0, a, 32'h0, 4'h0, v);
        check(name, v, exp);
    endtask

    task automatic wr(input int d, input logic [1:0] a, input logic [31:0] v, input logic [3:0] s);
        logic [31:0] dummy;
        bus(d, 1'b1, a, v, s, dummy);
    endtask

    task automatic wait_tx_low(output int t0);
        int n = 0;
        while (tx0 !== 1'b0 && n < 400) begin
            tick();
            n++;
        end
        if (n >= 400) check("tx_start_timeout", 32'h0, 32'h1);
        t0 = cyc_cnt;
    endtask

    // Mid-bit samples of one frame starting at t0, plus the start-bit boundary.
    task automatic check_frame(input logic [7:0] b, input int t0);
        wait_to(t0 + 8);
        check("tx_start_mid", {31'b0, tx0}, 32'h0);
        wait_to(t0 + 15);
        check("tx_start_end", {31'b0, tx0}, 32'h0);
        wait_to(t0 + 16);
        check("tx_bit0_begin", {31'b0, tx0}, {31'b0, b[0]});
        for (int k = 1; k <= 9; k++) begin
            wait_to(t0 + 8 + 16 * k);
            check($sformatf("tx_bit%0d", k), {31'b0, tx0}, (k == 9) ? 32'h1 : {31'b0, b[k-1]});
        end
    endtask

    task automatic send_rx(input int d, input logic [7:0] b, input logic stopb);
        logic [9:0] bits;
        bits = {stopb, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            if (d == 0) rxd0 = bits[i]; else rxd1 = bits[i];
            repeat (16) tick();
        end
        if (d == 0) rxd0 = 1'b1; else rxd1 = 1'b1;
        repeat (4) tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [17];
        int   t0, n;
        logic [31:0] v;

        vecs[0]  = '{0, 1'b0, 2'd0, 32'h0,        4'h0, 32'h000006C8};
        vecs[1]  = '{0, 1'b0, 2'd1, 32'h0,        4'h0, 32'h40100000};
        vecs[2]  = '{0, 1'b0, 2'd2, 32'h0,        4'h0, 32'h00000100};
        vecs[3]  = '{0, 1'b0, 2'd3, 32'h0,        4'h0, 32'h00000400};
        vecs[4]  = '{1, 1'b0, 2'd1, 32'h0,        4'h0, 32'h20040000};
        vecs[5]  = '{0, 1'b1, 2'd0, 32'h00000005, 4'h1, 32'h0};
        vecs[6]  = '{0, 1'b0, 2'd0, 32'h0,        4'h0, 32'h00000605};
        vecs[7]  = '{0, 1'b1, 2'd0, 32'hFF123456, 4'hF, 32'h0};
        vecs[8]  = '{0, 1'b0, 2'd0, 32'h0,        4'h0, 32'h00123456};
        vecs[9]  = '{0, 1'b1, 2'd0, 32'h00000003, 4'h7, 32'h0};
        vecs[10] = '{0, 1'b0, 2'd0, 32'h0,        4'h0, 32'h00000010};
        vecs[11] = '{0, 1'b1, 2'd0, 32'hAAAAAAAA, 4'h0, 32'h0};
        vecs[12] = '{0, 1'b0, 2'd0, 32'h0,        4'h0, 32'h00000010};
        vecs[13] = '{0, 1'b1, 2'd1, 32'hFFFFFFFF, 4'hF, 32'h0};
        vecs[14] = '{0, 1'b0, 2'd1, 32'h0,        4'h0, 32'h40100000};
        vecs[15] = '{0, 1'b1, 2'd0, 32'h00000010, 4'h1, 32'h0};
        vecs[16] = '{0, 1'b0, 2'd0, 32'h0,        4'h0, 32'h00000010};

        rst_n = 1'b0; cyc = 2'b00; stb = 1'b0; we = 1'b0; addr = 2'd0;
        wdat = 32'h0; sel = 4'h0; lb = 1'b0; rxd0 = 1'b1; rxd1 = 1'b1; cts_n = 1'b0;
        repeat (4) tick();

        check("rst_tx", {31'b0, tx0}, 32'h1);
        check("rst_ack", {31'b0, ack0}, 32'h0);
        check("rst_wbdata", rdat0, 32'h0);
        check("rst_rts", {31'b0, rts0}, 32'h0);
        check("rst_ints", {28'b0, rxi0, txi0, rxfi0, txfi0}, 32'h5);
        check("rst_stall", {31'b0, stall0}, 32'h0);
        rst_n = 1'b1;
        repeat (3) tick();

        for (int i = 0; i < 17; i++) begin
            bus(vecs[i].dut, vecs[i].we, vecs[i].addr, vecs[i].wd, vecs[i].sel, v);
            if (!vecs[i].we) check($sformatf("vec%0d", i), v, vecs[i].exp);
        end
        tick();
        check("ack_drop", {31'b0, ack0}, 32'h0);

        // Transmit 0x55 at 16 clocks per bit.
        wr(0, 2'd3, 32'h55, 4'h1);
        wait_tx_low(t0);
        rd_chk(0, 2'd3, "tx_busy_start", 32'h00000600);
        check_frame(8'h55, t0);
        wait_to(t0 + 158);
        rd_chk(0, 2'd3, "tx_busy_stop", 32'h00000600);
        check("tx_stop_end", {31'b0, tx0}, 32'h1);
        wait_to(t0 + 160);
        rd_chk(0, 2'd3, "tx_busy_clear", 32'h00000400);

        // Loopback 0xA3.
        lb = 1'b1;
        wr(0, 2'd3, 32'hA3, 4'h1);
        n = 0;
        while (rxi0 !== 1'b1 && n < 400) begin
            tick();
            n++;
        end
        check("lb_rx_int", {31'b0, rxi0}, 32'h1);
        rd_chk(0, 2'd2, "lb_rxdata", 32'h000000A3);
        rd_chk(0, 2'd2, "lb_empty", 32'h00000100);
        check("lb_rx_int_clear", {31'b0, rxi0}, 32'h0);
        repeat (20) tick();
        lb = 1'b0;

        // Frame error on a low stop bit, cleared by a write.
        send_rx(0, 8'h3C, 1'b0);
        rd_chk(0, 2'd2, "ferr_data", 32'h0000023C);
        rd_chk(0, 2'd2, "ferr_sticky", 32'h00000300);
        wr(0, 2'd2, 32'h0, 4'hF);
        rd_chk(0, 2'd2, "ferr_cleared", 32'h00000100);

        // Overrun on the depth-4 instance.
        wr(1, 2'd0, 32'h10, 4'h7);
        for (int i = 1; i <= 5; i++) send_rx(1, 8'(8'h11 * i), 1'b1);
        check("ovr_rxfifo_int", {31'b0, rxfi1}, 32'h1);
        check("ovr_rx_int", {31'b0, rxi1}, 32'h1);
`ifdef WBUART_HWFLOW_EN
        check("ovr_rts", {31'b0, rts1}, 32'h1);
`else
        check("ovr_rts", {31'b0, rts1}, 32'h0);
`endif
        rd_chk(1, 2'd1, "ovr_fifo_reg", 32'h20040004);
        for (int i = 1; i <= 4; i++)
            rd_chk(1, 2'd2, $sformatf("ovr_byte%0d", i), 32'h400 | 32'(8'h11 * i));
        rd_chk(1, 2'd2, "ovr_empty", 32'h00000500);
        tick();
        check("ovr_rxfifo_int_clear", {31'b0, rxfi1}, 32'h0);

`ifdef WBUART_HWFLOW_EN
        // Flow control: hold while CTS deasserted, then gapless frames.
        cts_n = 1'b1;
        repeat (4) tick();
        wr(0, 2'd3, 32'h0F, 4'h1);
        wr(0, 2'd3, 32'hF0, 4'h1);
        n = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (tx0 == 1'b0) n++;
        end
        check("cts_hold", 32'(n), 32'h0);
        check("rts_idle", {31'b0, rts0}, 32'h0);
        rd_chk(0, 2'd3, "cts_status", 32'h00000E00);
        cts_n = 1'b0;
        wait_tx_low(t0);
        check_frame(8'h0F, t0);
        wait_to(t0 + 159);
        check("b2b_stop", {31'b0, tx0}, 32'h1);
        wait_to(t0 + 160);
        check("b2b_start", {31'b0, tx0}, 32'h0);
        check_frame(8'hF0, t0 + 160);
        wait_to(t0 + 330);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
